// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad code sender and its bench-side keypad model:
// FSM state encoding, 2-bit verdict codes and a small parameter helper.
package keypad_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        GAP    = 3'd2,
        WAIT   = 3'd3,
        REPORT = 3'd4
    } kps_state_t;

    localparam logic [1:0] RES_TIMEOUT = 2'b00;
    localparam logic [1:0] RES_OPEN    = 2'b01;
    localparam logic [1:0] RES_FAIL    = 2'b10;
    localparam logic [1:0] RES_VIOL    = 2'b11;

    function automatic int kps_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/kps_cycle_timer.sv
// Loadable down-counter that stops at zero; zero is high once the loaded count has
// elapsed, so loading N-1 on state entry gives a state that lasts N cycles.
module kps_cycle_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             zero
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= value;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - WIDTH'(1);
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/keypad_code_sender.sv
// Serialises a passcode into one-cycle ZBUT/OBUT pulses and reports the keypad verdict.
// Optional feature macro KPS_RETRY_EN: one automatic resend after the first FAIL verdict.
module keypad_code_sender
    import keypad_pkg::*;
#(
    parameter int CODE_LEN = 4,
    parameter int GAP_CYC  = 2,
    parameter int TIMEOUT  = 8
) (
    input  logic                CLK,
    input  logic                RSTN,
    input  logic                START,
    input  logic [CODE_LEN-1:0] CODE,
    output logic                BUSY,
    output logic                DONE,
    output logic [1:0]          RESULT,
    output logic                ZBUT,
    output logic                OBUT,
    input  logic                ULCK,
    input  logic                RSTO,
    input  logic                SECV
);

    localparam int TW = $clog2(kps_max(GAP_CYC, TIMEOUT) + 1);
    localparam int IW = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;

    kps_state_t          state_reg, state_next;
    logic [IW-1:0]       idx_reg, idx_next;
    logic [CODE_LEN-1:0] code_reg, code_next;
    logic [1:0]          result_reg, result_next;
    logic                busy_reg, busy_next;
    logic                done_reg, done_next;
    logic                zbut_reg, zbut_next;
    logic                obut_reg, obut_next;
    logic                timer_load;
    logic [TW-1:0]       timer_value;
    logic                timer_zero;
`ifdef KPS_RETRY_EN
    logic                retried_reg, retried_next;
`endif

    kps_cycle_timer #(.WIDTH(TW)) u_timer (
        .clk   (CLK),
        .rst_n (RSTN),
        .load  (timer_load),
        .value (timer_value),
        .zero  (timer_zero)
    );

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_reg   <= IDLE;
            idx_reg     <= '0;
            code_reg    <= '0;
            result_reg  <= RES_TIMEOUT;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            zbut_reg    <= 1'b0;
            obut_reg    <= 1'b0;
`ifdef KPS_RETRY_EN
            retried_reg <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            code_reg    <= code_next;
            result_reg  <= result_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            zbut_reg    <= zbut_next;
            obut_reg    <= obut_next;
`ifdef KPS_RETRY_EN
            retried_reg <= retried_next;
`endif
        end
    end

    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        code_next    = code_reg;
        result_next  = result_reg;
        timer_load   = 1'b0;
        timer_value  = '0;
        zbut_next    = 1'b0;
        obut_next    = 1'b0;
`ifdef KPS_RETRY_EN
        retried_next = retried_reg;
`endif

        case (state_reg)
            IDLE: begin
                if (START) begin
                    code_next  = CODE;
                    idx_next   = IW'(CODE_LEN - 1);
                    state_next = DRIVE;
`ifdef KPS_RETRY_EN
                    retried_next = 1'b0;
`endif
                end
            end
            DRIVE: begin
                if (SECV) begin
                    result_next = RES_VIOL;
                    state_next  = REPORT;
                end else begin
                    timer_load  = 1'b1;
                    timer_value = TW'(GAP_CYC - 1);
                    state_next  = GAP;
                end
            end
            GAP: begin
                if (SECV) begin
                    result_next = RES_VIOL;
                    state_next  = REPORT;
                end else if (timer_zero) begin
                    if (idx_reg == '0) begin
                        timer_load  = 1'b1;
                        timer_value = TW'(TIMEOUT - 1);
                        state_next  = WAIT;
                    end else begin
                        idx_next   = idx_reg - IW'(1);
                        state_next = DRIVE;
                    end
                end
            end
            WAIT: begin
                if (SECV) begin
                    result_next = RES_VIOL;
                    state_next  = REPORT;
                end else if (RSTO) begin
`ifdef KPS_RETRY_EN
                    if (!retried_reg) begin
                        retried_next = 1'b1;
                        idx_next     = IW'(CODE_LEN - 1);
                        state_next   = DRIVE;
                    end else begin
                        result_next = RES_FAIL;
                        state_next  = REPORT;
                    end
`else
                    result_next = RES_FAIL;
                    state_next  = REPORT;
`endif
                end else if (ULCK) begin
                    result_next = RES_OPEN;
                    state_next  = REPORT;
                end else if (timer_zero) begin
                    result_next = RES_TIMEOUT;
                    state_next  = REPORT;
                end
            end
            REPORT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Outputs are registered alongside the state, so a pulse lines up with its DRIVE cycle.
        if (state_next == DRIVE) begin
            obut_next = code_next[idx_next];
            zbut_next = ~code_next[idx_next];
        end
        done_next = (state_next == REPORT);
        busy_next = (state_next != IDLE);
    end

    assign BUSY   = busy_reg;
    assign DONE   = done_reg;
    assign RESULT = result_reg;
    assign ZBUT   = zbut_reg;
    assign OBUT   = obut_reg;

endmodule
